writeback_regfile: RTL and testbench
====================================

Name: writeback_regfile

Overview:
Consumer end of the MEM/WB pipeline register, combining the writeback (WB) stage and the integer register file of the 5-stage RV32I pipeline. It selects the writeback result from the MEM/WB outputs and writes it into a 32x32 register file. It serves the two decode-stage read ports with same-cycle write-first bypass, and exports ResultW to the forwarding unit plus a debug read port and a retired-write counter.

Parameters:
XLEN, 32, data width of registers and result
NREG, 32, number of architectural registers (address width = 5)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
RegWriteW  input  1  register write enable from MEM/WB
ResultSrcW  input  2  result select from MEM/WB
ALUResultW  input  XLEN  ALU result from MEM/WB
ReadDataW  input  XLEN  data-memory read data from MEM/WB
PCPlus4W  input  XLEN  PC+4 from MEM/WB (JAL/JALR link)
RdW  input  5  destination register from MEM/WB
A1  input  5  decode read address, port 1 (rs1)
A2  input  5  decode read address, port 2 (rs2)
RD1  output  XLEN  read data, port 1
RD2  output  XLEN  read data, port 2
ResultW  output  XLEN  selected writeback value, to forwarding unit
DbgAddr  input  5  debug read address
DbgData  output  XLEN  debug read data (storage only, no bypass)
WbCount  output  32  count of committed register writes

Behaviour:
- Result mux (combinational):
  - ResultSrcW 00 -> ALUResultW
  - 01 -> ReadDataW
  - 10 -> PCPlus4W
  - 11 -> ALUResultW (reserved encoding, defined fallback)
- Write enable is we = RegWriteW && (RdW != 0) && !reset.
  - On rising clk with we=1: regs[RdW] <= ResultW.
  - One write per cycle.
- x0 is hardwired zero.
  - Writes to x0 are discarded and do not count.
  - Reads of address 0 on any port return 0.
- Read ports RD1/RD2 are combinational (zero-cycle latency).
  - If we=1 and A1==RdW (A1 != 0), RD1 = ResultW in the same cycle (write-first bypass, so no WB->ID hazard stall).
  - Same rule for A2/RD2.
  - Otherwise RDx = regs[Ax].
  - A1==A2 returns identical data on both ports, bypass included.
- DbgData = regs[DbgAddr] with no bypass; it shows the new value from the cycle after the write.
- WbCount increments by 1 on each rising edge with we=1.
  - Wraps 0xFFFFFFFF -> 0x00000000.
  - No saturation.
- Reset (asynchronous, any time including mid-operation):
  - All regs[1..31] <= 0 and WbCount <= 0 immediately on reset assertion.
  - While reset=1: RD1=RD2=DbgData=0, WbCount=0, bypass disabled, writes suppressed.
  - ResultW remains the combinational mux of its inputs.
- Reset release: the first write can occur on the first rising edge after deassertion.
- No X propagation: all storage is reset, and undefined ResultSrcW encodings are mapped as above.

Test Plan:
- Reset then read: assert reset, write attempt RegWriteW=1 RdW=5 ALUResultW=0x1234 ResultSrcW=00 -> after release, DbgAddr=5 gives 0, RD1 (A1=5) gives 0, WbCount=0.
- Result mux and write:
  - Cycle 1: RdW=3 ResultSrcW=01 ReadDataW=0xDEADBEEF -> regs[3]=0xDEADBEEF.
  - Cycle 2: RdW=4 ResultSrcW=10 PCPlus4W=0x104 -> regs[4]=0x104.
  - Cycle 3: RdW=6 ResultSrcW=11 ALUResultW=0x77 -> regs[6]=0x77.
  - After all three: WbCount=3.
- Bypass: regs[7]=0x11; same cycle RegWriteW=1 RdW=7 ALUResultW=0x22, A1=7 A2=7 -> RD1=RD2=0x22 before the edge, DbgData(7)=0x11 before and 0x22 after.
- x0 protection: RegWriteW=1 RdW=0 ALUResultW=0xFFFFFFFF, A1=0 -> RD1=0 before and after the edge, WbCount unchanged.
- RegWriteW=0: RdW=9 ALUResultW=0x55, A2=9 -> RD2 = old regs[9], no write, WbCount unchanged.
- Wrap and mid-operation reset: force WbCount to 0xFFFFFFFF, one valid write -> WbCount=0. Assert reset asynchronously mid-cycle during a write to x8 -> regs[8]=0 and outputs 0 without waiting for clk.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if
//   Bundles the MEM/WB writeback bus, the two decode read ports, the debug
//   read port and the retired-write counter of the writeback/regfile block.
//
//   Transfer rule: there is no backpressure on this bus. RegWriteW acts as
//   the valid of a one-cycle write transfer (RdW, ResultSrcW and the three
//   data operands). It is accepted on every rising clk edge where it is high,
//   RdW is non-zero and reset is low. The block has no ready signal.
//
//   master : pipeline side (drives MEM/WB fields and read addresses)
//   slave  : writeback_regfile (drives read data, ResultW, debug data, count)
interface writeback_regfile_if #(
   parameter int XLEN = 32
);
   logic            RegWriteW;
   logic [1:0]      ResultSrcW;
   logic [XLEN-1:0] ALUResultW;
   logic [XLEN-1:0] ReadDataW;
   logic [XLEN-1:0] PCPlus4W;
   logic [4:0]      RdW;
   logic [4:0]      A1;
   logic [4:0]      A2;
   logic [XLEN-1:0] RD1;
   logic [XLEN-1:0] RD2;
   logic [XLEN-1:0] ResultW;
   logic [4:0]      DbgAddr;
   logic [XLEN-1:0] DbgData;
   logic [31:0]     WbCount;

   modport master (
      output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW,
      output A1, A2, DbgAddr,
      input  RD1, RD2, ResultW, DbgData, WbCount
   );

   modport slave (
      input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW,
      input  A1, A2, DbgAddr,
      output RD1, RD2, ResultW, DbgData, WbCount
   );
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile
//   Writeback stage plus integer register file of the 5-stage RV32I pipeline.
//   Selects the writeback value from the MEM/WB fields, writes it into a
//   32x32 register file (x0 hardwired to zero), serves two combinational
//   decode read ports with write-first bypass, and exposes a bypass-free
//   debug read port and a count of committed register writes.
//
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high; clears registers and the counter
//     bus    : writeback_regfile_if.slave (MEM/WB fields, A1/A2 -> RD1/RD2,
//              ResultW, DbgAddr -> DbgData, WbCount)
module writeback_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input logic                clk,
   input logic                reset,
   writeback_regfile_if.slave bus
);

   logic [XLEN-1:0] regs [NREG];
   logic [31:0]     wb_count_q;
   logic [XLEN-1:0] result;
   logic            we;

   // Result select; the reserved encoding 11 falls back to the ALU result.
   always_comb begin
      result = bus.ALUResultW;
      case (bus.ResultSrcW)
         2'b01:   result = bus.ReadDataW;
         2'b10:   result = bus.PCPlus4W;
         default: result = bus.ALUResultW;
      endcase
   end

   // reset is part of the enable so that writes and bypass are both dead
   // while reset is held, and live again as soon as it drops.
   assign we = bus.RegWriteW && (bus.RdW != 5'd0) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
         wb_count_q <= '0;
      end else if (we) begin
         regs[bus.RdW] <= result;
         wb_count_q    <= wb_count_q + 32'd1;
      end
   end

   // Write-first read ports: a same-cycle write to the addressed register
   // is visible immediately, so WB->ID needs no stall.
   always_comb begin
      bus.RD1 = '0;
      bus.RD2 = '0;
      if (!reset) begin
         if (bus.A1 != 5'd0) begin
            bus.RD1 = (we && bus.A1 == bus.RdW) ? result : regs[bus.A1];
         end
         if (bus.A2 != 5'd0) begin
            bus.RD2 = (we && bus.A2 == bus.RdW) ? result : regs[bus.A2];
         end
      end
   end

   // Debug port shows storage only; a write appears the cycle after.
   always_comb begin
      bus.DbgData = '0;
      if (!reset && bus.DbgAddr != 5'd0) begin
         bus.DbgData = regs[bus.DbgAddr];
      end
   end

   assign bus.ResultW = result;
   assign bus.WbCount = wb_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   writeback_regfile_if #(.XLEN(32)) bus ();

   writeback_regfile #(.XLEN(32), .NREG(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic drive_idle();
      bus.RegWriteW  = 1'b0;
      bus.ResultSrcW = 2'b00;
      bus.ALUResultW = '0;
      bus.ReadDataW  = '0;
      bus.PCPlus4W   = '0;
      bus.RdW        = 5'd0;
      bus.A1         = 5'd0;
      bus.A2         = 5'd0;
      bus.DbgAddr    = 5'd0;
   endtask

   // One committed write through the ALU path, inputs changed at negedge.
   task automatic do_write(input logic [4:0] rd, input logic [31:0] val);
      @(negedge clk);
      bus.RegWriteW  = 1'b1;
      bus.ResultSrcW = 2'b00;
      bus.ALUResultW = val;
      bus.RdW        = rd;
      @(posedge clk);
      #1;
      bus.RegWriteW  = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b0;
      #1;
      reset = 1'b1;
      bus.RegWriteW  = 1'b1;
      bus.RdW        = 5'd5;
      bus.ALUResultW = 32'h1234;
      bus.ResultSrcW = 2'b00;
      bus.A1         = 5'd5;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (bus.RD1 !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_rd1_during: got %h expected %h", bus.RD1, 32'h0);
      end
      tests_run++;
      if (bus.ResultW !== 32'h1234) begin
         tests_failed++;
         $display("FAIL reset_resultw_mux: got %h expected %h", bus.ResultW, 32'h1234);
      end
      @(negedge clk);
      bus.RegWriteW = 1'b0;
      reset = 1'b0;
      bus.DbgAddr = 5'd5;
      #1;
      tests_run++;
      if (bus.DbgData !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_dbg5: got %h expected %h", bus.DbgData, 32'h0);
      end
      tests_run++;
      if (bus.RD1 !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_rd1_after: got %h expected %h", bus.RD1, 32'h0);
      end
      tests_run++;
      if (bus.WbCount !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_wbcount: got %h expected %h", bus.WbCount, 32'h0);
      end
   endtask

   task automatic test_result_mux();
      // Distinct values on unselected operands so a wrong select is visible.
      @(negedge clk);
      bus.RegWriteW  = 1'b1;
      bus.ALUResultW = 32'h0000_AAAA;
      bus.PCPlus4W   = 32'h0000_BBBB;
      bus.RdW        = 5'd3;
      bus.ResultSrcW = 2'b01;
      bus.ReadDataW  = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if (bus.ResultW !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL mux_sel01: got %h expected %h", bus.ResultW, 32'hDEAD_BEEF);
      end
      @(negedge clk);
      bus.RdW        = 5'd4;
      bus.ResultSrcW = 2'b10;
      bus.PCPlus4W   = 32'h0000_0104;
      #1;
      tests_run++;
      if (bus.ResultW !== 32'h0000_0104) begin
         tests_failed++;
         $display("FAIL mux_sel10: got %h expected %h", bus.ResultW, 32'h104);
      end
      @(negedge clk);
      bus.RdW        = 5'd6;
      bus.ResultSrcW = 2'b11;
      bus.ALUResultW = 32'h0000_0077;
      #1;
      tests_run++;
      if (bus.ResultW !== 32'h0000_0077) begin
         tests_failed++;
         $display("FAIL mux_sel11: got %h expected %h", bus.ResultW, 32'h77);
      end
      @(negedge clk);
      bus.RegWriteW = 1'b0;
      bus.DbgAddr = 5'd3;
      #1;
      tests_run++;
      if (bus.DbgData !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL mux_reg3: got %h expected %h", bus.DbgData, 32'hDEAD_BEEF);
      end
      bus.DbgAddr = 5'd4;
      #1;
      tests_run++;
      if (bus.DbgData !== 32'h0000_0104) begin
         tests_failed++;
         $display("FAIL mux_reg4: got %h expected %h", bus.DbgData, 32'h104);
      end
      bus.DbgAddr = 5'd6;
      #1;
      tests_run++;
      if (bus.DbgData !== 32'h0000_0077) begin
         tests_failed++;
         $display("FAIL mux_reg6: got %h expected %h", bus.DbgData, 32'h77);
      end
      tests_run++;
      if (bus.WbCount !== 32'd3) begin
         tests_failed++;
         $display("FAIL mux_wbcount: got %0d expected %0d", bus.WbCount, 3);
      end
   endtask

   task automatic test_bypass();
      do_write(5'd7, 32'h11);
      @(negedge clk);
      bus.RegWriteW  = 1'b1;
      bus.ResultSrcW = 2'b00;
      bus.RdW        = 5'd7;
      bus.ALUResultW = 32'h22;
      bus.A1         = 5'd7;
      bus.A2         = 5'd7;
      bus.DbgAddr    = 5'd7;
      #1;
      tests_run++;
      if (bus.RD1 !== 32'h22) begin
         tests_failed++;
         $display("FAIL bypass_rd1: got %h expected %h", bus.RD1, 32'h22);
      end
      tests_run++;
      if (bus.RD2 !== 32'h22) begin
         tests_failed++;
         $display("FAIL bypass_rd2: got %h expected %h", bus.RD2, 32'h22);
      end
      tests_run++;
      if (bus.DbgData !== 32'h11) begin
         tests_failed++;
         $display("FAIL bypass_dbg_before: got %h expected %h", bus.DbgData, 32'h11);
      end
      @(posedge clk);
      #1;
      bus.RegWriteW = 1'b0;
      #1;
      tests_run++;
      if (bus.DbgData !== 32'h22) begin
         tests_failed++;
         $display("FAIL bypass_dbg_after: got %h expected %h", bus.DbgData, 32'h22);
      end
      tests_run++;
      if (bus.RD1 !== 32'h22) begin
         tests_failed++;
         $display("FAIL bypass_rd1_stored: got %h expected %h", bus.RD1, 32'h22);
      end
      tests_run++;
      if (bus.WbCount !== 32'd5) begin
         tests_failed++;
         $display("FAIL bypass_wbcount: got %0d expected %0d", bus.WbCount, 5);
      end
   endtask

   task automatic test_x0();
      @(negedge clk);
      bus.RegWriteW  = 1'b1;
      bus.ResultSrcW = 2'b00;
      bus.RdW        = 5'd0;
      bus.ALUResultW = 32'hFFFF_FFFF;
      bus.A1         = 5'd0;
      bus.DbgAddr    = 5'd0;
      #1;
      tests_run++;
      if (bus.RD1 !== 32'h0) begin
         tests_failed++;
         $display("FAIL x0_rd1_before: got %h expected %h", bus.RD1, 32'h0);
      end
      @(posedge clk);
      #1;
      bus.RegWriteW = 1'b0;
      #1;
      tests_run++;
      if (bus.RD1 !== 32'h0) begin
         tests_failed++;
         $display("FAIL x0_rd1_after: got %h expected %h", bus.RD1, 32'h0);
      end
      tests_run++;
      if (bus.DbgData !== 32'h0) begin
         tests_failed++;
         $display("FAIL x0_dbg: got %h expected %h", bus.DbgData, 32'h0);
      end
      tests_run++;
      if (bus.WbCount !== 32'd5) begin
         tests_failed++;
         $display("FAIL x0_wbcount: got %0d expected %0d", bus.WbCount, 5);
      end
   endtask

   task automatic test_no_write();
      do_write(5'd9, 32'h99);
      @(negedge clk);
      bus.RegWriteW  = 1'b0;
      bus.RdW        = 5'd9;
      bus.ALUResultW = 32'h55;
      bus.A2         = 5'd9;
      bus.DbgAddr    = 5'd9;
      #1;
      tests_run++;
      if (bus.RD2 !== 32'h99) begin
         tests_failed++;
         $display("FAIL nowr_rd2_before: got %h expected %h", bus.RD2, 32'h99);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.RD2 !== 32'h99) begin
         tests_failed++;
         $display("FAIL nowr_rd2_after: got %h expected %h", bus.RD2, 32'h99);
      end
      tests_run++;
      if (bus.DbgData !== 32'h99) begin
         tests_failed++;
         $display("FAIL nowr_dbg: got %h expected %h", bus.DbgData, 32'h99);
      end
      tests_run++;
      if (bus.WbCount !== 32'd6) begin
         tests_failed++;
         $display("FAIL nowr_wbcount: got %0d expected %0d", bus.WbCount, 6);
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.wb_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.wb_count_q;
      #1;
      tests_run++;
      if (bus.WbCount !== 32'hFFFF_FFFF) begin
         tests_failed++;
         $display("FAIL wrap_preload: got %h expected %h", bus.WbCount, 32'hFFFF_FFFF);
      end
      do_write(5'd10, 32'h3);
      tests_run++;
      if (bus.WbCount !== 32'h0) begin
         tests_failed++;
         $display("FAIL wrap_wbcount: got %h expected %h", bus.WbCount, 32'h0);
      end
      bus.DbgAddr = 5'd10;
      #1;
      tests_run++;
      if (bus.DbgData !== 32'h3) begin
         tests_failed++;
         $display("FAIL wrap_reg10: got %h expected %h", bus.DbgData, 32'h3);
      end
   endtask

   task automatic test_async_reset();
      do_write(5'd8, 32'h88);
      @(negedge clk);
      bus.RegWriteW  = 1'b1;
      bus.ResultSrcW = 2'b00;
      bus.RdW        = 5'd8;
      bus.ALUResultW = 32'h99;
      bus.A1         = 5'd8;
      bus.A2         = 5'd8;
      bus.DbgAddr    = 5'd8;
      #1;
      tests_run++;
      if (bus.RD1 !== 32'h99) begin
         tests_failed++;
         $display("FAIL arst_bypass: got %h expected %h", bus.RD1, 32'h99);
      end
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (bus.RD1 !== 32'h0) begin
         tests_failed++;
         $display("FAIL arst_rd1: got %h expected %h", bus.RD1, 32'h0);
      end
      tests_run++;
      if (bus.RD2 !== 32'h0) begin
         tests_failed++;
         $display("FAIL arst_rd2: got %h expected %h", bus.RD2, 32'h0);
      end
      tests_run++;
      if (bus.WbCount !== 32'h0) begin
         tests_failed++;
         $display("FAIL arst_wbcount: got %h expected %h", bus.WbCount, 32'h0);
      end
      tests_run++;
      if (bus.ResultW !== 32'h99) begin
         tests_failed++;
         $display("FAIL arst_resultw: got %h expected %h", bus.ResultW, 32'h99);
      end
      // Peek storage directly while reset holds the debug port at zero.
      tests_run++;
      if (dut.regs[8] !== 32'h0) begin
         tests_failed++;
         $display("FAIL arst_reg8: got %h expected %h", dut.regs[8], 32'h0);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.WbCount !== 32'h0) begin
         tests_failed++;
         $display("FAIL arst_held_wbcount: got %h expected %h", bus.WbCount, 32'h0);
      end
      // Release with the write still presented: it commits on the next edge.
      @(negedge clk);
      reset = 1'b0;
      bus.A1 = 5'd0;
      #1;
      tests_run++;
      if (bus.DbgData !== 32'h0) begin
         tests_failed++;
         $display("FAIL arst_dbg_released: got %h expected %h", bus.DbgData, 32'h0);
      end
      @(posedge clk);
      #1;
      bus.RegWriteW = 1'b0;
      #1;
      tests_run++;
      if (bus.DbgData !== 32'h99) begin
         tests_failed++;
         $display("FAIL arst_first_write: got %h expected %h", bus.DbgData, 32'h99);
      end
      tests_run++;
      if (bus.WbCount !== 32'd1) begin
         tests_failed++;
         $display("FAIL arst_first_count: got %0d expected %0d", bus.WbCount, 1);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_result_mux();
      test_bypass();
      test_x0();
      test_no_write();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
